// File: rtl/pxs_pkg.sv
// Shared definitions for the PixelStream chain: stream field positions,
// 640x480@60 timing defaults and background pattern codes.
package pxs_pkg;

    localparam int STREAM_W = 26;
    localparam int ACTIVE   = 0;
    localparam int VS       = 1;
    localparam int HS       = 2;
    localparam int YC_LSB   = 3;
    localparam int YC_MSB   = 12;
    localparam int XC_LSB   = 13;
    localparam int XC_MSB   = 22;
    localparam int R        = 23;
    localparam int G        = 24;
    localparam int B        = 25;

    localparam int CNT_W    = 10;
    localparam int FRAME_W  = 16;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef enum logic [1:0] {
        PAT_BLACK = 2'b00,
        PAT_BARS  = 2'b01,
        PAT_CHECK = 2'b10,
        PAT_SOLID = 2'b11
    } pat_e;

    // 32-pixel checkerboard: white where the column and row tile bits differ.
    function automatic logic [2:0] checker_rgb(input logic i_hbit, input logic i_vbit);
        return (i_hbit ^ i_vbit) ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/pxs_timing_counter.sv
// Horizontal/vertical raster counters with enable and a completed-frame counter.
module pxs_timing_counter
    import pxs_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    output logic [CNT_W-1:0]   o_hc,
    output logic [CNT_W-1:0]   o_vc,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0]   r_hc;
    logic [CNT_W-1:0]   r_vc;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               w_h_last;
    logic               w_v_last;

    assign w_h_last = (r_hc == H_LAST);
    assign w_v_last = (r_vc == V_LAST);

    // A wrap is only taken on an enabled cycle, so a stall on the last beat defers it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_frame_cnt <= '0;
        end else if (i_en) begin
            if (w_h_last) begin
                r_hc <= '0;
                if (w_v_last) begin
                    r_vc        <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_vc <= r_vc + 1'b1;
                end
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    assign o_hc        = r_hc;
    assign o_vc        = r_vc;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/pxs_vga_source.sv
// Head of the PixelStream chain: VGA timing plus a frame-synchronous background
// pattern, emitted as a registered 26-bit stream with one beat of latency.
module pxs_vga_source
    import pxs_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = 1'b0,
    parameter int BAR_W     = H_VISIBLE / 8
) (
    input  logic                px_clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          pattern_sel,
    input  logic [2:0]          bg_rgb,
    output logic [STREAM_W-1:0] RGBStr_o,
    output logic                sof_o,
    output logic [FRAME_W-1:0]  frame_cnt_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_L  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS_L  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [STREAM_W-1:0] RST_STREAM = STREAM_W'({~SYNC_POL, ~SYNC_POL, 1'b0});

    logic [CNT_W-1:0]    w_hc;
    logic [CNT_W-1:0]    w_vc;
    logic                w_at_origin;
    logic                w_active;
    logic                w_hs;
    logic                w_vs;
    pat_e                w_pat;
    logic [2:0]          w_bg;
    logic [2:0]          w_bar_idx;
    logic [2:0]          w_pat_rgb;
    logic [2:0]          w_rgb;
    pat_e                r_pat;
    logic [2:0]          r_bg;
    logic [STREAM_W-1:0] r_stream;
    logic                r_sof;

    pxs_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .i_clk       (px_clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .o_hc        (w_hc),
        .o_vc        (w_vc),
        .o_frame_cnt (frame_cnt_o)
    );

    assign w_at_origin = (w_hc == '0) && (w_vc == '0);
    assign w_active    = (w_hc < H_VIS_L) && (w_vc < V_VIS_L);
    assign w_hs        = ((w_hc >= HS_BEG) && (w_hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs        = ((w_vc >= VS_BEG) && (w_vc < VS_END)) ? SYNC_POL : ~SYNC_POL;

    // The origin beat already uses the live selection so a new pattern starts on the sof beat.
    assign w_pat = w_at_origin ? pat_e'(pattern_sel) : r_pat;
    assign w_bg  = w_at_origin ? bg_rgb : r_bg;

    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_hc >= CNT_W'(k * BAR_W)) begin
                w_bar_idx = 3'(k);
            end
        end
        w_pat_rgb = 3'b000;
        case (w_pat)
            PAT_BLACK: w_pat_rgb = 3'b000;
            PAT_BARS:  w_pat_rgb = ~w_bar_idx;
            PAT_CHECK: w_pat_rgb = checker_rgb(w_hc[5], w_vc[5]);
            PAT_SOLID: w_pat_rgb = w_bg;
            default:   w_pat_rgb = 3'b000;
        endcase
        w_rgb = w_active ? w_pat_rgb : 3'b000;
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stream <= RST_STREAM;
            r_sof    <= 1'b0;
            r_pat    <= PAT_BLACK;
            r_bg     <= 3'b000;
        end else begin
            r_sof <= 1'b0;
            if (en) begin
                r_stream <= {w_rgb, w_hc, w_vc, w_hs, w_vs, w_active};
                r_sof    <= w_at_origin;
                if (w_at_origin) begin
                    r_pat <= pat_e'(pattern_sel);
                    r_bg  <= bg_rgb;
                end
            end
        end
    end

    assign RGBStr_o = r_stream;
    assign sof_o    = r_sof;

endmodule
